// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, majority-of-three bit decisions,
// and a single-entry valid/ready output register with overrun and framing detection.
module uart_rx_os16 #(
  parameter int baudrate = 115200,
  parameter int clkHz    = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int OS_DIV = clkHz / (16 * baudrate);
  localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state;
  logic        sync1;
  logic        line;
  logic        line_prev;
  logic [CW-1:0] os_cnt;
  logic [3:0]  sample_cnt;
  logic [2:0]  bit_idx;
  logic        s7;
  logic        s8;
  logic [7:0]  shreg;
  logic        tick;
  logic        maj;

  assign tick = (os_cnt == CW'(OS_DIV - 1));
  assign maj  = (s7 & s8) | (s7 & line) | (s8 & line);

  // Tick counter is held at zero in IDLE so the first tick lands OS_DIV cycles after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sync1          <= 1'b1;
      line           <= 1'b1;
      line_prev      <= 1'b1;
      os_cnt         <= '0;
      sample_cnt     <= '0;
      bit_idx        <= '0;
      s7             <= 1'b0;
      s8             <= 1'b0;
      shreg          <= '0;
      data           <= 8'h00;
      data_out_valid <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      sync1     <= uart_rx;
      line      <= sync1;
      line_prev <= line;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (data_out_valid && data_out_ready)
        data_out_valid <= 1'b0;

      if (state == IDLE || tick)
        os_cnt <= '0;
      else
        os_cnt <= os_cnt + 1'b1;

      if (tick && state != IDLE) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (sample_cnt == 4'd7) s7 <= line;
        if (sample_cnt == 4'd8) s8 <= line;
      end

      case (state)
        IDLE: begin
          if (line_prev && !line) begin
            state      <= START;
            sample_cnt <= '0;
            bit_idx    <= '0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (tick && sample_cnt == 4'd9 && maj) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick && sample_cnt == 4'd15) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (tick && sample_cnt == 4'd9)
            shreg <= {maj, shreg[7:1]};
          if (tick && sample_cnt == 4'd15) begin
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (tick && sample_cnt == 4'd9) begin
            if (maj) begin
              // A full output register is only overwritten when it is being consumed this cycle.
              if (!data_out_valid || data_out_ready) begin
                data           <= shreg;
                data_out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (line) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of 8N1 frames plus hand sequences
// for false start, overrun and mid-frame reset.
module tb_uart_rx_os16;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int BIT_CYC = 160;
  // Drive at posedge P0: 2 synchronizer flops + edge detect put START at P3, then 154 ticks of 10 cycles.
  localparam int LATENCY = 1543;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] data;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int passed = 0;

  int         cyc = 0;
  int         xfers = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         vcyc = 0;
  int         last_rise = 0;
  logic [7:0] last_data = 8'h00;
  logic       valid_prev = 1'b0;

  int start_cyc;
  int snap_x, snap_f, snap_o, snap_v;

  typedef struct {
    logic [7:0] payload;
    logic       stop_bit;
    int         idle_after;
    logic [7:0] exp_data;
    int         exp_xfers;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_os16 #(.baudrate(BAUD), .clkHz(CLK_HZ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rx        (uart_rx),
    .data           (data),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts transfers, valid-high cycles and error pulses on the falling edge.
  always @(negedge clk) begin
    if (data_out_valid && data_out_ready) begin
      xfers     = xfers + 1;
      last_data = data;
    end
    if (data_out_valid) vcyc = vcyc + 1;
    if (data_out_valid && !valid_prev) last_rise = cyc;
    valid_prev = data_out_valid;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual == expected)
      passed = passed + 1;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    wait_cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CYC);
    drive_bit(stop_bit, BIT_CYC);
    uart_rx = 1'b1;
  endtask

  task automatic snapshot();
    snap_x = xfers;
    snap_f = ferr_cnt;
    snap_o = ovr_cnt;
    snap_v = vcyc;
  endtask

  task automatic applyStimulus(input vec_t v);
    snapshot();
    send_frame(v.payload, v.stop_bit);
    wait_cycles(v.idle_after);
  endtask

  initial begin
    vecs[0] = '{8'h47, 1'b1, 40,  8'h47, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0,   8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0,   8'hFF, 1, 0};
    vecs[3] = '{8'hA5, 1'b1, 40,  8'hA5, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 160, 8'hA5, 0, 1};
    vecs[5] = '{8'h55, 1'b1, 40,  8'h55, 1, 0};

    rst_n          = 1'b0;
    uart_rx        = 1'b1;
    data_out_ready = 1'b1;
    #12;
    checkOutput("reset data", int'(data), 0);
    checkOutput("reset valid", int'(data_out_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset frame_err", int'(frame_err), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(20);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d transfers", i), xfers - snap_x, vecs[i].exp_xfers);
      checkOutput($sformatf("vec%0d data", i), int'(data), int'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d frame_err", i), ferr_cnt - snap_f, vecs[i].exp_ferr);
      checkOutput($sformatf("vec%0d overrun", i), ovr_cnt - snap_o, 0);
      checkOutput($sformatf("vec%0d valid cycles", i), vcyc - snap_v, vecs[i].exp_xfers);
      if (vecs[i].exp_xfers == 1) begin
        checkOutput($sformatf("vec%0d rx byte", i), int'(last_data), int'(vecs[i].exp_data));
        checkOutput($sformatf("vec%0d latency", i), last_rise - start_cyc, LATENCY);
      end
    end

    // Short low glitch: START must be entered and then abandoned silently.
    snapshot();
    drive_bit(1'b0, 20);
    checkOutput("glitch busy", int'(busy), 1);
    drive_bit(1'b1, 300);
    checkOutput("glitch idle", int'(busy), 0);
    checkOutput("glitch transfers", xfers - snap_x, 0);
    checkOutput("glitch frame_err", ferr_cnt - snap_f, 0);
    checkOutput("glitch overrun", ovr_cnt - snap_o, 0);

    // Consumer stalled: second byte is dropped and the first is held.
    data_out_ready = 1'b0;
    snapshot();
    send_frame(8'h11, 1'b1);
    wait_cycles(20);
    checkOutput("stall valid", int'(data_out_valid), 1);
    checkOutput("stall data", int'(data), 8'h11);
    send_frame(8'h22, 1'b1);
    wait_cycles(20);
    checkOutput("overrun pulses", ovr_cnt - snap_o, 1);
    checkOutput("overrun data held", int'(data), 8'h11);
    checkOutput("overrun no transfer", xfers - snap_x, 0);
    data_out_ready = 1'b1;
    wait_cycles(5);
    checkOutput("release transfers", xfers - snap_x, 1);
    checkOutput("release byte", int'(last_data), 8'h11);
    checkOutput("release valid clear", int'(data_out_valid), 0);

    // Reset in the middle of bit 3 of 0x99, then a clean 0x66.
    snapshot();
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b1, BIT_CYC);
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b1, 80);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset data", int'(data), 0);
    checkOutput("midreset valid", int'(data_out_valid), 0);
    checkOutput("midreset busy", int'(busy), 0);
    wait_cycles(20);
    rst_n = 1'b1;
    wait_cycles(50);
    send_frame(8'h66, 1'b1);
    wait_cycles(20);
    checkOutput("post-reset transfers", xfers - snap_x, 1);
    checkOutput("post-reset byte", int'(last_data), 8'h66);
    checkOutput("post-reset frame_err", ferr_cnt - snap_f, 0);
    checkOutput("post-reset overrun", ovr_cnt - snap_o, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 The block SHALL have parameter baudrate, default 115200, meaning the serial bit rate in bits per second.
REQ-002 The block SHALL have parameter clkHz, default 100_000_000, meaning the clk frequency in Hz.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port uart_rx, input, 1 bit, the asynchronous serial line; it idles high.
REQ-006 The block SHALL have port data, output, 8 bits, the received byte.
REQ-007 The block SHALL have port data_out_valid, output, 1 bit; high means data holds an unconsumed byte.
REQ-008 The block SHALL have port data_out_ready, input, 1 bit, the consumer accept signal.
REQ-009 The block SHALL have port frame_err, output, 1 bit, a 1-cycle pulse when the stop bit is bad.
REQ-010 The block SHALL have port overrun, output, 1 bit, a 1-cycle pulse when a completed byte is dropped.
REQ-011 The block SHALL have port busy, output, 1 bit; it is high whenever the FSM is not in IDLE.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer before any use; all references to "line" below mean the synchronized value.
REQ-013 An oversample tick SHALL be generated every OS_DIV = clkHz/(16*baudrate) clk cycles, using integer division; the counter width is $clog2(OS_DIV).
REQ-014 The tick counter SHALL be cleared on entry to START, so that ticks align to the detected falling edge.
REQ-015 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; each bit spans 16 ticks, counted by a 4-bit sample counter.
REQ-016 IDLE: a line transition 1->0 SHALL move the FSM to START, with the sample counter at 0.
REQ-017 Each bit value SHALL be the majority of the line samples at ticks 7, 8 and 9; the decision is made at tick 9.
REQ-018 START: if the majority is 0, the FSM SHALL wait for tick 15 and then go to DATA; if the majority is 1 (false start), it SHALL return to IDLE immediately with no outputs asserted.
REQ-019 DATA: bits SHALL be shifted in LSB first, 8 bits counted by a 3-bit index; after the 8th bit's tick 15 the FSM SHALL go to STOP.
REQ-020 STOP, majority 1: the byte SHALL be delivered per REQ-022/023 at the tick-9 decision cycle, and the FSM SHALL go to IDLE in the same cycle (no wait for tick 15).
REQ-021 STOP, majority 0: frame_err SHALL pulse for 1 cycle, the byte is discarded, and the FSM SHALL go to WAIT_HIGH, which returns to IDLE on the first cycle the line is 1.
REQ-022 Delivery with data_out_valid=0, or with data_out_valid=1 and data_out_ready=1 in the same cycle: data SHALL load the new byte and data_out_valid SHALL be 1 the next cycle.
REQ-023 Delivery with data_out_valid=1 and data_out_ready=0: the new byte SHALL be dropped, data SHALL keep the old byte, and overrun SHALL pulse for 1 cycle.
REQ-024 Handshake: a transfer occurs when data_out_valid and data_out_ready are both high on a rising edge; data_out_valid SHALL then clear unless a delivery happens in the same cycle; data SHALL be stable while data_out_valid=1.
REQ-025 Latency: data_out_valid SHALL rise exactly 1 clk after the stop-bit tick-9 decision cycle.
REQ-026 Back-to-back frames with zero idle between stop and the next start SHALL be received without loss.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously force: FSM to IDLE, all counters to 0, synchronizer flops to 1, data=8'h00, data_out_valid=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, no byte or error from that frame SHALL be reported, and the next full frame SHALL be received correctly.
REQ-029 Reset release SHALL take effect synchronously to clk.

Verification
REQ-030 Use clkHz=1_600_000 and baudrate=10_000 (OS_DIV=10). Drive 8N1 frame 0x47 with data_out_ready=1 -> data=8'h47, data_out_valid high for 1 cycle, frame_err=0, overrun=0.
REQ-031 Drive frames 0x00, 0xFF, 0xA5 back-to-back with data_out_ready=1 -> three valid transfers in order, with no errors.
REQ-032 Drive frame 0x3C with the stop bit held 0, then the line high -> frame_err pulses once, data_out_valid stays 0, and the next frame 0x55 is received as 8'h55.
REQ-033 Drive a low glitch of 20 clk (2 ticks) on an idle line -> FSM returns to IDLE, with no valid, frame_err or overrun.
REQ-034 Hold data_out_ready=0 and drive 0x11 then 0x22 -> data=8'h11 is held, overrun pulses once at the second stop bit; then set ready=1 -> one transfer of 0x11.
REQ-035 Assert rst_n=0 during bit 3 of frame 0x99, release, then drive 0x66 -> only 8'h66 is reported, with no errors.
